// File: rtl/regfile_perf_pkg.sv
// Shared types and constants for the register file with performance counters.
package regfile_perf_pkg;

  // Measurement window state; the encoding is visible in STATUS[1:0].
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCount  = 2'd1,
    StFrozen = 2'd2
  } win_state_e;

  // Register map.
  localparam logic [4:0] AddrZero   = 5'd0;
  localparam logic [4:0] AddrStatus = 5'd23;
  localparam logic [4:0] AddrCyc    = 5'd24;
  localparam logic [4:0] AddrInstr  = 5'd25;
  localparam logic [4:0] AddrStall  = 5'd26;
  localparam logic [4:0] AddrArith  = 5'd27;
  localparam logic [4:0] AddrMem    = 5'd28;
  localparam logic [4:0] AddrLeds   = 5'd29;
  localparam logic [4:0] AddrSw     = 5'd30;
  localparam logic [4:0] AddrLink   = 5'd31;

  // Counter slots, in address order starting at AddrCyc.
  localparam int unsigned NumCnt   = 5;
  localparam int unsigned CntCyc   = 0;
  localparam int unsigned CntInstr = 1;
  localparam int unsigned CntStall = 2;
  localparam int unsigned CntArith = 3;
  localparam int unsigned CntMem   = 4;

  // Retire classes that feed the ARITH and MEM counters.
  localparam logic [2:0] ClsAlu    = 3'b000;
  localparam logic [2:0] ClsAluImm = 3'b001;
  localparam logic [2:0] ClsLoad   = 3'b100;
  localparam logic [2:0] ClsStore  = 3'b101;

  // Addresses backed by plain storage: 1..22 and the LED register.
  function automatic logic is_gpr(logic [4:0] addr);
    return (addr != AddrZero) && ((addr < AddrStatus) || (addr == AddrLeds));
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Event counter with synchronous clear, preset and sticky overflow flag.
module perf_counter #(
  parameter int unsigned Width    = 32,
  parameter bit          Saturate = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             clr_i,
  output logic [Width-1:0] value_o,
  output logic             overflow_o
);

  logic [Width-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;

  // Priority: clear, then preset, then increment.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      if (&value_q) begin
        ovf_d   = 1'b1;
        value_d = Saturate ? value_q : '0;
      end else begin
        value_d = value_q + 1'b1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o    = value_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/regfile_perf.sv
// 32-entry register file with special read-only sources and a window of
// memory-mapped performance counters.
module regfile_perf
  import regfile_perf_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned SW_W     = 3,
  parameter int unsigned LED_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [4:0]                     wa,
  input  logic [DATA_W-1:0]              wd,
  input  logic [NUM_RD-1:0][4:0]         ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
  input  logic [DATA_W-1:0]              pc_plus8,
  input  logic [SW_W-1:0]                switches,
  output logic [LED_W-1:0]               leds,
  input  logic                           win_start,
  input  logic                           win_stop,
  input  logic                           cnt_clr,
  input  logic                           retire_valid,
  input  logic                           stall,
  input  logic [2:0]                     retire_class
);

  win_state_e        state_q, state_d;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] cnt_val [NumCnt];
  logic [NumCnt-1:0] cnt_inc, cnt_load, cnt_ovf;
  logic [DATA_W-1:0] status;
  logic              counting, retire_ok;

  // Window FSM next state; a clear always wins, stop beats a same-cycle start.
  always_comb begin
    state_d = state_q;
    if (cnt_clr) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFrozen: if (win_start && !win_stop) state_d = StCount;
        StCount:          if (win_stop) state_d = StFrozen;
        default:          state_d = StIdle;
      endcase
    end
  end

  // Window state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Event decode; stalled retirements are not counted as instructions.
  always_comb begin
    counting            = (state_q == StCount);
    retire_ok           = counting && retire_valid && !stall;
    cnt_inc             = '0;
    cnt_inc[CntCyc]     = counting;
    cnt_inc[CntInstr]   = retire_ok;
    cnt_inc[CntStall]   = counting && stall;
    cnt_inc[CntArith]   = retire_ok && (retire_class == ClsAlu || retire_class == ClsAluImm);
    cnt_inc[CntMem]     = retire_ok && (retire_class == ClsLoad || retire_class == ClsStore);
  end

  for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
    assign cnt_load[k] = we && (wa == AddrCyc + 5'(k));

    perf_counter #(
      .Width    (DATA_W),
      .Saturate (SATURATE)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (cnt_inc[k]),
      .load_i     (cnt_load[k]),
      .load_val_i (wd),
      .clr_i      (cnt_clr),
      .value_o    (cnt_val[k]),
      .overflow_o (cnt_ovf[k])
    );
  end

  // Plain storage writes; counters, STATUS and the fixed sources are excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 32; j++) regs_q[j] <= '0;
    end else if (we && is_gpr(wa)) begin
      regs_q[wa] <= wd;
    end
  end

  // STATUS layout: [1:0] window state, [8:4] sticky overflow per counter.
  always_comb begin
    status      = '0;
    status[1:0] = state_q;
    status[8:4] = cnt_ovf;
  end

  // Read ports with same-cycle write bypass for addresses 1..29.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd[i] = '0;
      if (we && (wa == ra[i]) && (wa != AddrZero) && (wa <= AddrLeds)) begin
        rd[i] = wd;
      end else begin
        case (ra[i])
          AddrZero:   rd[i] = '0;
          AddrStatus: rd[i] = status;
          AddrCyc:    rd[i] = cnt_val[CntCyc];
          AddrInstr:  rd[i] = cnt_val[CntInstr];
          AddrStall:  rd[i] = cnt_val[CntStall];
          AddrArith:  rd[i] = cnt_val[CntArith];
          AddrMem:    rd[i] = cnt_val[CntMem];
          AddrSw:     rd[i] = DATA_W'(switches);
          AddrLink:   rd[i] = pc_plus8;
          default:    rd[i] = regs_q[ra[i]];
        endcase
      end
    end
  end

  assign leds = regs_q[AddrLeds][LED_W-1:0];

endmodule

// File: tb/tb_regfile_perf.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared every cycle against a behavioural model of the register map.
module tb_regfile_perf;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             we, cnt_clr, win_start, win_stop, retire_valid, stall;
  logic [4:0]       wa;
  logic [31:0]      wd, pc_plus8;
  logic [2:0]       switches, retire_class;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd0, rd1;
  logic [7:0]       leds0, leds1;

  always #5 clk = ~clk;

  regfile_perf #(
    .DATA_W(32), .NUM_RD(2), .SW_W(3), .LED_W(8), .SATURATE(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd0),
    .pc_plus8(pc_plus8), .switches(switches), .leds(leds0), .win_start(win_start),
    .win_stop(win_stop), .cnt_clr(cnt_clr), .retire_valid(retire_valid), .stall(stall),
    .retire_class(retire_class)
  );

  regfile_perf #(
    .DATA_W(32), .NUM_RD(2), .SW_W(3), .LED_W(8), .SATURATE(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd1),
    .pc_plus8(pc_plus8), .switches(switches), .leds(leds1), .win_start(win_start),
    .win_stop(win_stop), .cnt_clr(cnt_clr), .retire_valid(retire_valid), .stall(stall),
    .retire_class(retire_class)
  );

  // Model: variant 0 wraps, variant 1 saturates. State 0 idle, 1 count, 2 frozen.
  logic [31:0] m_reg [32];
  logic [31:0] m_cnt [2][5];
  bit          m_ovf [2][5];
  int          m_state;
  int          checks = 0;
  int          passes = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int a = 0; a < 32; a++) m_reg[a] = '0;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 5; k++) begin
        m_cnt[v][k] = '0;
        m_ovf[v][k] = 1'b0;
      end
    m_state = 0;
  endfunction

  function automatic logic [31:0] m_status(int v);
    logic [31:0] s;
    s = 32'(m_state);
    for (int k = 0; k < 5; k++) if (m_ovf[v][k]) s = s | (32'd1 << (4 + k));
    return s;
  endfunction

  function automatic logic [31:0] m_read(int v, int a);
    if (we && int'(wa) == a && a >= 1 && a <= 29) return wd;
    if (a == 0) return '0;
    if (a == 30) return {29'd0, switches};
    if (a == 31) return pc_plus8;
    if (a == 23) return m_status(v);
    if (a >= 24 && a <= 28) return m_cnt[v][a-24];
    return m_reg[a];
  endfunction

  // Advance the model by one rising edge using the currently applied inputs.
  function automatic void model_step();
    bit ev [5];
    bit ret, cnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cnt   = (m_state == 1);
    ret   = retire_valid && !stall;
    ev[0] = cnt;
    ev[1] = cnt && ret;
    ev[2] = cnt && stall;
    ev[3] = cnt && ret && (retire_class == 3'd0 || retire_class == 3'd1);
    ev[4] = cnt && ret && (retire_class == 3'd4 || retire_class == 3'd5);
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 5; k++) begin
        if (cnt_clr) begin
          m_cnt[v][k] = '0;
          m_ovf[v][k] = 1'b0;
        end else if (we && int'(wa) == 24 + k) begin
          m_cnt[v][k] = wd;
        end else if (ev[k]) begin
          if (m_cnt[v][k] == 32'hFFFF_FFFF) begin
            m_ovf[v][k] = 1'b1;
            if (v == 0) m_cnt[v][k] = '0;
          end else begin
            m_cnt[v][k] = m_cnt[v][k] + 32'd1;
          end
        end
      end
    if (we && ((wa >= 5'd1 && wa <= 5'd22) || wa == 5'd29)) m_reg[wa] = wd;
    if (cnt_clr) m_state = 0;
    else if (m_state == 1 && win_stop) m_state = 2;
    else if (m_state != 1 && win_start && !win_stop) m_state = 1;
  endfunction

  // Per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rd0[%0d] ra=%0d", i, ra[i]), rd0[i], m_read(0, int'(ra[i])));
        check($sformatf("rd1[%0d] ra=%0d", i, ra[i]), rd1[i], m_read(1, int'(ra[i])));
      end
      check("leds0", {24'd0, leds0}, {24'd0, m_reg[29][7:0]});
      check("leds1", {24'd0, leds1}, {24'd0, m_reg[29][7:0]});
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; cnt_clr = 1'b0; win_start = 1'b0; win_stop = 1'b0;
    retire_valid = 1'b0; stall = 1'b0; retire_class = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    pc_plus8 = 32'h0000_1008;
    switches = 3'b101;
    ra[0] = 5'd24;
    ra[1] = 5'd23;
    model_reset();
    chk_en = 1'b1;
    #1;
    check("reset CYC", rd0[0], 32'd0);
    check("reset STATUS", rd0[1], 32'd0);
    check("reset leds", {24'd0, leds0}, 32'd0);
    cycle(); cycle();
    rst_n = 1'b1;

    // Same-cycle bypass, then ignored write to address 0.
    we = 1'b1; wa = 5'd5; wd = 32'h0000_DEAD; ra[0] = 5'd5;
    #1 check("bypass addr5", rd0[0], 32'h0000_DEAD);
    cycle(); we = 1'b0;
    #1 check("stored addr5", rd0[0], 32'h0000_DEAD);
    we = 1'b1; wa = 5'd0; wd = 32'd123; ra[0] = 5'd0; ra[1] = 5'd30;
    #1 check("addr0 with write", rd0[0], 32'd0);
    check("switches", rd0[1], 32'd5);
    cycle(); we = 1'b0;
    #1 check("addr0 after write", rd0[0], 32'd0);

    // Window: 10 counted cycles with 3 stalls and 4 class-000 retires.
    win_start = 1'b1; cycle(); win_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      stall        = (c == 1 || c == 4 || c == 7);
      retire_valid = (c == 0 || c == 2 || c == 3 || c == 5);
      retire_class = 3'b000;
      cycle();
    end
    stall = 1'b0; retire_valid = 1'b0;
    ra[0] = 5'd24; ra[1] = 5'd26;
    #1 check("CYC=10", rd0[0], 32'd10);
    check("STALL=3", rd0[1], 32'd3);
    ra[0] = 5'd25; ra[1] = 5'd27;
    #1 check("INSTR=4", rd0[0], 32'd4);
    check("ARITH=4", rd0[1], 32'd4);
    ra[0] = 5'd28;
    #1 check("MEM=0", rd0[0], 32'd0);

    // The cycle carrying win_stop is still counted (11); the resume edge is not.
    win_stop = 1'b1; cycle(); win_stop = 1'b0;
    repeat (5) cycle();
    win_start = 1'b1; cycle(); win_start = 1'b0;
    cycle();
    ra[0] = 5'd24; ra[1] = 5'd23;
    #1 check("CYC=12 after resume", rd0[0], 32'd12);
    check("STATUS COUNT", rd0[1], 32'd1);

    // Overflow: wrap vs saturate.
    we = 1'b1; wa = 5'd24; wd = 32'hFFFF_FFFE; cycle(); we = 1'b0;
    repeat (3) cycle();
    #1 check("wrap CYC", rd0[0], 32'd1);
    check("wrap STATUS", rd0[1], 32'h11);
    check("sat CYC", rd1[0], 32'hFFFF_FFFF);
    check("sat STATUS", rd1[1], 32'h11);

    we = 1'b1; wa = 5'd29; wd = 32'h1234_56A5; cycle(); we = 1'b0;
    #1 check("leds A5", {24'd0, leds0}, 32'hA5);

    // Clear beats a same-cycle counter write.
    cnt_clr = 1'b1; we = 1'b1; wa = 5'd25; wd = 32'd7; cycle();
    cnt_clr = 1'b0; we = 1'b0;
    ra[0] = 5'd25; ra[1] = 5'd23;
    #1 check("clr INSTR", rd0[0], 32'd0);
    check("clr STATUS", rd0[1], 32'd0);
    check("clr STATUS sat", rd1[1], 32'd0);

    // Reset mid-window.
    win_start = 1'b1; cycle(); win_start = 1'b0;
    repeat (3) cycle();
    ra[0] = 5'd24;
    rst_n = 1'b0; model_reset();
    #1 check("rst leds", {24'd0, leds0}, 32'd0);
    check("rst CYC", rd0[0], 32'd0);
    check("rst STATUS", rd0[1], 32'd0);
    cycle(); rst_n = 1'b1;
    repeat (3) cycle();
    #1 check("no count after rst", rd0[0], 32'd0);
    check("IDLE after rst", rd0[1], 32'd0);
    win_start = 1'b1; cycle(); win_start = 1'b0;
    cycle(); cycle();
    #1 check("count after restart", rd0[0], 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      we           = ($urandom_range(0, 2) == 0);
      wa           = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(23, 28))
                                                 : 5'($urandom_range(0, 31));
      wd           = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : $urandom;
      ra[0]        = 5'($urandom_range(0, 31));
      ra[1]        = 5'($urandom_range(0, 31));
      win_start    = ($urandom_range(0, 15) == 0);
      win_stop     = ($urandom_range(0, 31) == 0);
      cnt_clr      = ($urandom_range(0, 127) == 0);
      retire_valid = $urandom_range(0, 1) == 1;
      stall        = ($urandom_range(0, 3) == 0);
      retire_class = 3'($urandom_range(0, 7));
      switches     = 3'($urandom_range(0, 7));
      pc_plus8     = $urandom;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 511) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      cycle();
    end

    idle_inputs();
    rst_n = 1'b1;
    cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_perf.md
REGFILE_PERF -- requirements
Module: regfile_perf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and counter width.
REQ-002 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-003 SHALL have parameter SW_W, default 3, switch input width.
REQ-004 SHALL have parameter LED_W, default 8, LED output width.
REQ-005 SHALL have parameter SATURATE, default 0; 1 means counters saturate at all-ones, 0 means they wrap.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port we, input, 1 bit: register write enable.
REQ-009 SHALL have port wa, input, 5 bits: write address.
REQ-010 SHALL have port wd, input, DATA_W bits: write data.
REQ-011 SHALL have port ra, input, NUM_RD x 5 bits: read addresses.
REQ-012 SHALL have port rd, output, NUM_RD x DATA_W bits: read data.
REQ-013 SHALL have port pc_plus8, input, DATA_W bits: value returned for address 31.
REQ-014 SHALL have port switches, input, SW_W bits: value returned for address 30.
REQ-015 SHALL have port leds, output, LED_W bits: equals reg[29][LED_W-1:0].
REQ-016 SHALL have ports win_start, win_stop and cnt_clr, input, 1 bit each: measurement-window control pulses.
REQ-017 SHALL have ports retire_valid and stall, input, 1 bit each: pipeline events.
REQ-018 SHALL have port retire_class, input, 3 bits: class of the retiring instruction.

Function
REQ-019 SHALL return, per read port (combinational): 0 for addr 0; zero-extended switches for addr 30; pc_plus8 for addr 31; otherwise reg[ra].
REQ-020 SHALL bypass reads: when we=1, wa==ra[i] and wa is in 1..29, rd[i] SHALL equal wd in the same cycle.
REQ-021 SHALL ignore writes to addresses 0, 30 and 31.
REQ-022 SHALL map counters as: 23 STATUS (read-only; bits[1:0]=state, bits[8:4]=sticky overflow per counter); 24 CYC; 25 INSTR; 26 STALL; 27 ARITH; 28 MEM.
REQ-023 SHALL implement a window FSM with states IDLE, COUNT and FROZEN.
REQ-024 SHALL transition IDLE->COUNT and FROZEN->COUNT on win_start, resuming without clearing counters.
REQ-025 SHALL transition COUNT->FROZEN on win_stop; win_start and win_stop asserted together SHALL be treated as win_stop.
REQ-026 SHALL, on cnt_clr (highest priority), zero all counters and overflow bits and go to IDLE on the next edge.
REQ-027 SHALL, in COUNT only: increment CYC every cycle; increment STALL when stall=1; when retire_valid=1 and stall=0, increment INSTR and, for retire_class 000/001, ARITH or, for 100/101, MEM; other classes affect INSTR only.
REQ-028 SHALL, on overflow: with SATURATE=0, wrap to 0 and set the sticky bit; with SATURATE=1, hold all-ones and set the sticky bit.
REQ-029 SHALL, on a write to addresses 24..28, preset that counter to wd; a write in the same cycle as an increment SHALL win.
REQ-030 SHALL let cnt_clr override a same-cycle write to a counter.
REQ-031 SHALL ignore writes to address 23.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronous), set all registers, counters and sticky bits to 0, the state to IDLE, and leds to 0.
REQ-033 SHALL abort an active window on reset assertion and SHALL restart only on a win_start after rst_n deasserts.

Structure
REQ-034 SHALL place the state enum, address constants (STATUS=23 ... LINK=31) and class codes in package regfile_perf_pkg.
REQ-035 SHALL instantiate one sub-module, perf_counter (inc, load, clr, SATURATE; outputs value and overflow), five times.

Verification
REQ-036 SHALL cover: write 0xDEAD to addr 5 with ra[0]=5 in the same cycle -> rd[0]=0xDEAD combinationally; write to addr 0 -> addr 0 reads 0.
REQ-037 SHALL cover: win_start, 10 cycles with 3 stalls and 4 retires of class 000 -> CYC=10, STALL=3, INSTR=4, ARITH=4, MEM=0.
REQ-038 SHALL cover: win_stop, 5 idle cycles, win_start, 2 cycles -> CYC=12; STATUS state=COUNT.
REQ-039 SHALL cover: preset CYC to 0xFFFFFFFE, count 3 cycles -> with SATURATE=0, CYC=1 and sticky bit4=1; with SATURATE=1, CYC=0xFFFFFFFF and bit4=1.
REQ-040 SHALL cover: cnt_clr together with a write of 7 to addr 25 -> INSTR=0, state IDLE.
REQ-041 SHALL cover: rst_n low mid-window -> all counters 0, leds 0 immediately; no counting until win_start.
